if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage. It owns the PC, fetches from instruction memory over a req/ack bus, and drives if_pc/if_inst into the IF/ID pipeline register. It honours the pipeline stall vector, applies MIPS-style branch redirects (one delay slot) and raises a stall request while memory has not answered.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; address of the first fetch.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
stall  in  6  pipeline stall vector; stall[0]=1 freezes the PC/fetch stage.
branch_flag_i  in  1  ID-stage branch taken; redirects the fetch after the delay slot.
branch_target_i  in  32  branch destination; valid when branch_flag_i=1.
inst_req_o  out  1  memory request.
inst_addr_o  out  32  fetch address; equals the current PC.
inst_ack_i  in  1  memory response valid; may be high in the same cycle as the request.
inst_rdata_i  in  32  instruction word; valid when inst_ack_i=1.
if_pc  out  32  PC of the delivered instruction, registered.
if_inst  out  32  delivered instruction, registered.
stallreq_if  out  1  combinational; high while a request is outstanding and unanswered.

Behaviour:
- Reset (rst=1 at an edge): state<=IDLE, pc<=RESET_PC, if_pc<=0, if_inst<=0, buffer and pending-branch registers cleared. rst overrides every other input.
- Reset with a request outstanding: the request is abandoned, and no ack is consumed in IDLE. The next fetch is from RESET_PC.
- States:
  - IDLE: one cycle after reset; inst_req_o=0; goes to REQ.
  - REQ: inst_req_o=1, inst_addr_o=pc.
  - HOLD: inst_req_o=0; holds a fetched word while stall[0]=1.
- Bus rule: inst_addr_o stays constant while inst_req_o=1 until inst_ack_i=1. A zero-wait ack completes in the same cycle.
- REQ with inst_ack_i=1 and stall[0]=0 (delivery):
  - if_pc<=pc, if_inst<=inst_rdata_i.
  - pc<=next_pc; stay in REQ. The next request issues in the following cycle, giving 1 instruction/cycle with zero-wait memory.
- REQ with inst_ack_i=1 and stall[0]=1: buf<=inst_rdata_i, go to HOLD. if_pc/if_inst and pc are unchanged.
- HOLD with stall[0]=0 (delivery from buffer): if_pc<=pc, if_inst<=buf, pc<=next_pc, go to REQ.
- REQ with inst_ack_i=0: no register change. stallreq_if=1 (state==REQ and inst_ack_i==0); it is 0 in every other case.
- next_pc:
  - branch_flag_i=1 this cycle: branch_target_i.
  - else a pending branch is set: the stored target.
  - else pc+PC_STEP.
  - Addition is 32-bit and wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Pending branch:
  - Set, with the target stored, when branch_flag_i=1 in a cycle with no delivery.
  - Cleared on the next delivery, which then uses the stored target.
  - A new branch_flag_i overwrites an older pending target.
  - Branch and delivery in the same cycle: the live target is used and pending stays clear.
- The word being delivered when the branch is seen is the delay slot and is always delivered, never squashed.
- if_pc/if_inst hold their value between deliveries. IF/ID is frozen by the stall controller while stallreq_if=1.

Test Plan:
- Reset, then zero-wait memory returning addr|32'hA000_0000: if_pc = 0,4,8,C on consecutive cycles; if_inst matches; stallreq_if stays 0.
- Ack delayed 3 cycles on the fetch of 0x8: inst_addr_o held at 0x8 and stallreq_if=1 for 3 cycles; if_pc=0x8 one edge after the ack.
- stall[0]=1 for 2 cycles coinciding with the ack for 0x10: state goes to HOLD and inst_req_o=0. When stall[0] drops, if_pc=0x10 and if_inst=the buffered word; the next request is for 0x14.
- branch_flag_i=1, target 0x100, during delivery of 0xC: delivery of 0xC completes (delay slot); the next inst_addr_o is 0x100.
- branch_flag_i=1, target 0x200, pulsed while a fetch of 0x20 is waiting for ack: 0x20 is delivered, then the fetch goes to 0x200, not 0x24.
- rst asserted while REQ is unanswered, with a late ack during IDLE: the ack is ignored, if_pc/if_inst=0, and the first new request is to RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and
// feeds the IF/ID register with delay-slot branch redirects.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_q;
   logic        pend;
   logic [31:0] pend_tgt;

   logic        frz;
   logic        got;
   logic        deliver;
   logic [31:0] next_pc;
   logic        unused_stall;

   assign unused_stall = ^stall[5:1];
   assign frz          = stall[0];
   assign got          = (state == REQ) && inst_ack_i;
   assign deliver      = (got && !frz) || ((state == HOLD) && !frz);

   always_comb begin
      next_pc = pc + PC_STEP;
      if (branch_flag_i)
         next_pc = branch_target_i;
      else if (pend)
         next_pc = pend_tgt;
   end

   assign inst_req_o  = (state == REQ);
   assign inst_addr_o = pc;
   assign stallreq_if = (state == REQ) && !inst_ack_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         if_pc    <= 32'h0;
         if_inst  <= 32'h0;
         hold_q   <= 32'h0;
         pend     <= 1'b0;
         pend_tgt <= 32'h0;
      end else begin
         unique case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (got && frz) begin
                  hold_q <= inst_rdata_i;
                  state  <= HOLD;
               end else if (got) begin
                  if_pc   <= pc;
                  if_inst <= inst_rdata_i;
                  pc      <= next_pc;
               end
            end
            HOLD: begin
               if (!frz) begin
                  if_pc   <= pc;
                  if_inst <= hold_q;
                  pc      <= next_pc;
                  state   <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
         // a live branch seen on a delivery is consumed immediately
         if (deliver) begin
            pend <= 1'b0;
         end else if (branch_flag_i) begin
            pend     <= 1'b1;
            pend_tgt <= branch_target_i;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed plan steps, then random bus/stall/branch
// traffic checked against a transaction-level model.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = 6'h0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_i = 32'h0;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_ack_i = 1'b0;
   logic [31:0] inst_rdata_i;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_if;

   int n_assert = 0;
   int n_fail   = 0;

   // model: address of the instruction in flight, whether a fetched word
   // is being held back, and the most recent unconsumed branch target
   logic        m_started = 1'b0;
   logic [31:0] m_pc = 32'h0;
   logic        m_have = 1'b0;
   logic [31:0] m_word = 32'h0;
   logic        m_pend = 1'b0;
   logic [31:0] m_tgt = 32'h0;
   logic [31:0] e_pc = 32'h0;
   logic [31:0] e_inst = 32'h0;

   always #5 clk = ~clk;

   assign inst_rdata_i = inst_addr_o | 32'hA000_0000;

   if_fetch #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag_i(branch_flag_i),
      .branch_target_i(branch_target_i),
      .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
      .inst_ack_i(inst_ack_i), .inst_rdata_i(inst_rdata_i),
      .if_pc(if_pc), .if_inst(if_inst),
      .stallreq_if(stallreq_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic a, input logic s,
                      input logic b, input logic [31:0] t);
      logic req;
      logic del;
      logic [31:0] w;
      chk("if_pc", if_pc, e_pc);
      chk("if_inst", if_inst, e_inst);
      rst = r;
      inst_ack_i = a;
      stall = {5'b10101, s};
      branch_flag_i = b;
      branch_target_i = t;
      #1;
      req = m_started && !m_have;
      chk("inst_req_o", {31'h0, inst_req_o}, {31'h0, req});
      if (req) chk("inst_addr_o", inst_addr_o, m_pc);
      chk("stallreq_if", {31'h0, stallreq_if}, {31'h0, req && !a});
      if (r) begin
         m_started = 1'b0;
         m_pc = 32'h0;
         m_have = 1'b0;
         m_pend = 1'b0;
         e_pc = 32'h0;
         e_inst = 32'h0;
      end else begin
         w = m_have ? m_word : (m_pc | 32'hA000_0000);
         del = !s && (m_have || (req && a));
         if (del) begin
            e_pc = m_pc;
            e_inst = w;
            m_pc = b ? t : (m_pend ? m_tgt : m_pc + 32'd4);
            m_pend = 1'b0;
            m_have = 1'b0;
         end else begin
            if (req && a) begin
               m_have = 1'b1;
               m_word = w;
            end
            if (b) begin
               m_pend = 1'b1;
               m_tgt = t;
            end
         end
         m_started = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("req_after_idle", {31'h0, inst_req_o}, 32'h1);
      // zero-wait memory
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("zw_pc4", if_pc, 32'h4);
      chk("zw_inst4", if_inst, 32'hA000_0004);
      // three wait cycles on 0x8
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("wait_addr8", inst_addr_o, 32'h8);
      cyc(0, 1, 0, 0, 0);
      chk("wait_pc8", if_pc, 32'h8);
      // branch during delivery of 0xC
      cyc(0, 1, 0, 1, 32'h100);
      chk("slot_pcC", if_pc, 32'hC);
      chk("br_addr100", inst_addr_o, 32'h100);
      // stalled ack, buffered delivery
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("hold_req0", {31'h0, inst_req_o}, 32'h0);
      cyc(0, 0, 1, 0, 0);
      chk("hold_pc100", if_pc, 32'h100);
      cyc(0, 0, 0, 0, 0);
      chk("buf_pc104", if_pc, 32'h104);
      chk("buf_inst104", if_inst, 32'hA000_0104);
      chk("buf_next108", inst_addr_o, 32'h108);
      // branch while 0x108 waits
      cyc(0, 0, 0, 1, 32'h200);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("pend_pc108", if_pc, 32'h108);
      chk("pend_addr200", inst_addr_o, 32'h200);
      // wrap at the top of the address space
      cyc(0, 1, 0, 1, 32'hFFFF_FFFC);
      cyc(0, 1, 0, 0, 0);
      chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_addr0", inst_addr_o, 32'h0);
      // reset with a request outstanding, late ack in IDLE
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_pc0", if_pc, 32'h0);
      cyc(0, 1, 0, 0, 0);
      chk("idle_ack_pc", if_pc, 32'h0);
      chk("idle_ack_inst", if_inst, 32'h0);
      chk("rst_addr0", inst_addr_o, 32'h0);
      cyc(0, 1, 0, 0, 0);
      chk("rst_first_inst", if_inst, 32'hA000_0000);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] t;
         t = {$urandom(), 2'b00} >> 0;
         t[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
         cyc($urandom_range(0, 63) == 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0,
             t);
      end
      cyc(0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
